// File: rtl/ram16x1024_port_arbiter.sv
// ram16x1024_port_arbiter
// Shares one 16x1024 two-port RAM between two write requesters and two
// read requesters. Each RAM port has its own two-way round-robin arbiter.
// Grants are combinational from the requests. Read data comes back one
// cycle after the grant, with a one-hot valid tag. Same-cycle write/read
// hits to the same address are counted in a saturating 16-bit counter.
//
// Optional feature: define RAM_ARB_BYPASS_EN for write-first behaviour on a
// collision. The write data is forwarded to rd_data in the following cycle.
// Without the macro, a colliding read returns the old RAM contents
// (read-first), and no forwarding registers exist.

module ram16x1024_port_arbiter #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [1:0]    wr_req,
  input  logic [AW-1:0] wr_addr0,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] wr_data0,
  input  logic [DW-1:0] wr_data1,
  output logic [1:0]    wr_gnt,

  input  logic [1:0]    rd_req,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [1:0]    rd_gnt,
  output logic [1:0]    rd_vld,
  output logic [DW-1:0] rd_data,

  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,

  output logic [15:0]   coll_cnt
);

  // Two-way round robin: under contention the pointer picks the winner.
  // A lone request (or none) passes straight through as the grant.
  function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic ptr);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
    return gnt;
  endfunction

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] rd_tag;
  logic       coll;

  // Write and read grants; both are held at zero while reset is asserted.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 2'b00;
    if (!rst) begin
      wr_gnt = rr_grant(wr_req, wr_ptr);
      rd_gnt = rr_grant(rd_req, rd_ptr);
    end
  end

  // After granting requester i, the pointer moves to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (wr_gnt[0]) begin
        wr_ptr <= 1'b1;
      end else if (wr_gnt[1]) begin
        wr_ptr <= 1'b0;
      end
      if (rd_gnt[0]) begin
        rd_ptr <= 1'b1;
      end else if (rd_gnt[1]) begin
        rd_ptr <= 1'b0;
      end
    end
  end

  // RAM port muxes: steer the granted requester's address and data to the RAM.
  always_comb begin
    ram_w_en   = |wr_gnt;
    ram_w_addr = wr_gnt[1] ? wr_addr1 : wr_addr0;
    ram_w_data = wr_gnt[1] ? wr_data1 : wr_data0;
    ram_r_en   = |rd_gnt;
    ram_r_addr = rd_gnt[1] ? rd_addr1 : rd_addr0;
    coll       = ram_w_en & ram_r_en & (ram_w_addr == ram_r_addr);
  end

  // The read tag follows the RAM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_tag <= 2'b00;
    end else begin
      rd_tag <= rd_gnt;
    end
  end

  // A read granted just before reset must not return, so mask the valid during reset.
  always_comb begin
    rd_vld = rst ? 2'b00 : rd_tag;
  end

  // Saturating collision counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt <= 16'h0000;
    end else if (coll && (coll_cnt != 16'hFFFF)) begin
      coll_cnt <= coll_cnt + 16'h0001;
    end
  end

`ifdef RAM_ARB_BYPASS_EN
  logic          byp_vld;
  logic [DW-1:0] byp_data;

  // Capture the colliding write so the following read return sees the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_vld  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_vld <= coll;
      if (coll) begin
        byp_data <= ram_w_data;
      end
    end
  end

  // Return data: the forwarded write value after a collision, otherwise the RAM.
  always_comb begin
    rd_data = byp_vld ? byp_data : ram_r_data;
  end
`else
  // Return data comes straight from the RAM (read-first on a collision).
  always_comb begin
    rd_data = ram_r_data;
  end
`endif

endmodule

// File: tb/tb_ram16x1024_port_arbiter.sv
// Directed, table-driven bench for ram16x1024_port_arbiter, with a
// behavioural read-first two-port RAM attached to the RAM ports.
// The expected collision read data follows RAM_ARB_BYPASS_EN.

module tb_ram16x1024_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 10;

`ifdef RAM_ARB_BYPASS_EN
  localparam logic [15:0] COLL_DATA = 16'h2222;
`else
  localparam logic [15:0] COLL_DATA = 16'h1111;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_req;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    wr_gnt;
  logic [1:0]    rd_req;
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [1:0]    rd_gnt;
  logic [1:0]    rd_vld;
  logic [DW-1:0] rd_data;
  logic          ram_w_en;
  logic [AW-1:0] ram_w_addr;
  logic [DW-1:0] ram_w_data;
  logic          ram_r_en;
  logic [AW-1:0] ram_r_addr;
  logic [DW-1:0] ram_r_data;
  logic [15:0]   coll_cnt;

  int checks = 0;
  int failures = 0;

  ram16x1024_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .coll_cnt(coll_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural two-port RAM, read-first, registered read output.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_r_data = '0;
  end
  always @(posedge clk) begin
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  wr_req;
    logic [9:0]  wa0, wa1;
    logic [15:0] wd0, wd1;
    logic [1:0]  rd_req;
    logic [9:0]  ra0, ra1;
    logic [1:0]  exp_wr_gnt, exp_rd_gnt, exp_rd_vld;
    logic [9:0]  exp_w_addr;
    logic [15:0] exp_rd_data;
    logic [15:0] exp_coll;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    wr_req   = v.wr_req;
    wr_addr0 = v.wa0;
    wr_addr1 = v.wa1;
    wr_data0 = v.wd0;
    wr_data1 = v.wd1;
    rd_req   = v.rd_req;
    rd_addr0 = v.ra0;
    rd_addr1 = v.ra1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    chk({tag, ".wr_gnt"}, 32'(wr_gnt), 32'(v.exp_wr_gnt));
    chk({tag, ".rd_gnt"}, 32'(rd_gnt), 32'(v.exp_rd_gnt));
    chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(v.exp_rd_vld));
    chk({tag, ".ram_w_en"}, 32'(ram_w_en), 32'(|v.exp_wr_gnt));
    chk({tag, ".ram_r_en"}, 32'(ram_r_en), 32'(|v.exp_rd_gnt));
    chk({tag, ".coll_cnt"}, 32'(coll_cnt), 32'(v.exp_coll));
    if (v.exp_wr_gnt != 2'b00) begin
      chk({tag, ".ram_w_addr"}, 32'(ram_w_addr), 32'(v.exp_w_addr));
      chk({tag, ".ram_w_data"}, 32'(ram_w_data), 32'(v.exp_wr_gnt[1] ? v.wd1 : v.wd0));
    end
    if (v.exp_rd_vld != 2'b00) begin
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(v.exp_rd_data));
    end
  endtask

  function automatic vec_t idle(input logic r, input logic [15:0] coll);
    vec_t v;
    v = '{r, 2'b00, 10'h0, 10'h0, 16'h0, 16'h0, 2'b00, 10'h0, 10'h0,
          2'b00, 2'b00, 2'b00, 10'h0, 16'h0, coll};
    return v;
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1; wr_req = 2'b00; rd_req = 2'b00;
    wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_addr0 = '0; rd_addr1 = '0;
    repeat (2) @(posedge clk);

    //            rst wr_req wa0     wa1     wd0       wd1      rd_req ra0     ra1     wgnt   rgnt   rvld   waddr   rdata      coll
    vecs.push_back('{1'b1, 2'b11, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b11, 10'h000, 10'h000, 2'b00, 2'b00, 2'b00, 10'h000, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b11, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b11, 10'h100, 10'h200, 2'b01, 2'b01, 2'b00, 10'h001, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b11, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b01, 10'h002, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b11, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 10'h001, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b11, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 10'h002, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b10, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 10'h002, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b10, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 10'h002, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b10, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b10, 2'b00, 2'b00, 10'h002, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b11, 10'h001, 10'h002, 16'h0001, 16'h0002, 2'b00, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 10'h001, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b01, 10'h3FF, 10'h000, 16'hA5A5, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 10'h3FF, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b10, 10'h000, 10'h3FF, 2'b00, 2'b10, 2'b00, 10'h000, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b10, 10'h000, 16'hA5A5, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b01, 10'h001, 10'h000, 2'b00, 2'b01, 2'b00, 10'h000, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b10, 10'h000, 10'h002, 2'b00, 2'b10, 2'b01, 10'h000, 16'h0001, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b11, 10'h3FF, 10'h001, 2'b00, 2'b01, 2'b10, 10'h000, 16'h0002, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b11, 10'h3FF, 10'h001, 2'b00, 2'b10, 2'b01, 10'h000, 16'hA5A5, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b10, 10'h000, 16'h0001, 16'd0});
    vecs.push_back('{1'b0, 2'b01, 10'h010, 10'h000, 16'h1111, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b01, 2'b00, 2'b00, 10'h010, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b01, 10'h010, 10'h000, 16'h2222, 16'h0000, 2'b01, 10'h010, 10'h000, 2'b01, 2'b01, 2'b00, 10'h010, 16'h0000, 16'd0});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b01, 10'h000, COLL_DATA, 16'd1});
    vecs.push_back('{1'b0, 2'b01, 10'h020, 10'h000, 16'h3333, 16'h0000, 2'b10, 10'h000, 10'h010, 2'b01, 2'b10, 2'b00, 10'h020, 16'h0000, 16'd1});
    vecs.push_back('{1'b0, 2'b00, 10'h000, 10'h000, 16'h0000, 16'h0000, 2'b00, 10'h000, 10'h000, 2'b00, 2'b00, 2'b10, 10'h000, 16'h2222, 16'd1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Drive the counter to saturation with repeated same-address collisions.
    v = '{1'b0, 2'b01, 10'h005, 10'h000, 16'h5555, 16'h0000, 2'b01, 10'h005, 10'h000,
          2'b01, 2'b01, 2'b00, 10'h005, 16'h0000, 16'd0};
    for (int n = 0; n < 65533; n++) applyStimulus(v);
    applyStimulus(idle(1'b0, 16'hFFFE));
    chk("sat.fffe", 32'(coll_cnt), 32'h0000_FFFE);
    applyStimulus(v);
    applyStimulus(idle(1'b0, 16'hFFFF));
    chk("sat.ffff", 32'(coll_cnt), 32'h0000_FFFF);
    applyStimulus(v);
    applyStimulus(v);
    applyStimulus(idle(1'b0, 16'hFFFF));
    chk("sat.hold", 32'(coll_cnt), 32'h0000_FFFF);

    // A read granted just before reset never returns a valid.
    v = idle(1'b0, 16'hFFFF);
    v.rd_req = 2'b01;
    v.ra0 = 10'h005;
    applyStimulus(v);
    chk("pend.rd_gnt", 32'(rd_gnt), 32'h1);
    v = idle(1'b1, 16'hFFFF);
    v.wr_req = 2'b11;
    v.rd_req = 2'b11;
    applyStimulus(v);
    chk("pend.rd_vld_in_rst", 32'(rd_vld), 32'h0);
    chk("pend.wr_gnt_in_rst", 32'(wr_gnt), 32'h0);
    chk("pend.ram_r_en_in_rst", 32'(ram_r_en), 32'h0);
    applyStimulus(idle(1'b1, 16'h0));
    chk("pend.coll_clear", 32'(coll_cnt), 32'h0);
    chk("pend.rd_vld_rst2", 32'(rd_vld), 32'h0);
    applyStimulus(idle(1'b0, 16'h0));
    chk("pend.rd_vld_after", 32'(rd_vld), 32'h0);
    chk("pend.coll_after", 32'(coll_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
